// File: rtl/imm_encoder_pkg.sv
// Shared package for the rotated-immediate encoder: field widths and the FSM state type.
// IMM_ENCODER_MVN_EN adds the INV_SEARCH state for the inverted-value search.
package imm_encoder_pkg;

   localparam int ROT_W  = 4;
   localparam int IMM8_W = 8;
   localparam int SHOP_W = 12;

   localparam logic [ROT_W-1:0] ROT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SEARCH     = 2'd1,
`ifdef IMM_ENCODER_MVN_EN
      INV_SEARCH = 2'd2,
`endif
      DONE       = 2'd3
   } state_t;

endpackage

// File: rtl/imm_encoder_rol2_unit.sv
// Combinational 32-bit rotate-left by twice the rotate field.
// Produces the candidate immediate tested by the search FSM.
module rol2_unit
   import imm_encoder_pkg::*;
(
   input  logic [31:0]      i_data,
   input  logic [ROT_W-1:0] i_rot,
   output logic [31:0]      o_data
);

   logic [4:0] w_sh;
   logic [5:0] w_back;

   assign w_sh   = {i_rot, 1'b0};
   assign w_back = 6'd32 - {1'b0, w_sh};

   // A zero rotate is handled separately so the right shift never reaches 32.
   assign o_data = (w_sh == 5'd0) ? i_data
                                  : ((i_data << w_sh) | (i_data >> w_back));

endmodule

// File: rtl/imm_encoder.sv
// Sequential search for the smallest rotate that expresses a 32-bit value as ROR(imm8, 2*rot).
// With IMM_ENCODER_MVN_EN a second pass searches ~value and flags the result with inv.
//
// state      | meaning
// IDLE       | waiting for a request, in_ready=1
// SEARCH     | testing rotate r against the latched value, one candidate per cycle
// INV_SEARCH | same search on the inverted value (IMM_ENCODER_MVN_EN only)
// DONE       | result held with out_valid=1 until out_ready
module imm_encoder
   import imm_encoder_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       value,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SHOP_W-1:0] shifter_operand,
   output logic              ok,
   output logic              inv
);

   state_t              r_state, nx_state;
   logic [ROT_W-1:0]    r_rot, nx_rot;
   logic [31:0]         r_value, nx_value;
   logic [SHOP_W-1:0]   r_shop, nx_shop;
   logic                r_ok, nx_ok;
   logic [31:0]         w_src;
   logic [31:0]         w_cand;
   logic                w_hit;

`ifdef IMM_ENCODER_MVN_EN
   logic                r_inv, nx_inv;

   assign w_src = (r_state == INV_SEARCH) ? ~r_value : r_value;
   assign inv   = r_inv;
`else
   assign w_src = r_value;
   assign inv   = 1'b0;
`endif

   rol2_unit u_rol2 (
      .i_data (w_src),
      .i_rot  (r_rot),
      .o_data (w_cand)
   );

   assign w_hit           = (w_cand[31:IMM8_W] == '0);
   assign in_ready        = (r_state == IDLE);
   assign out_valid       = (r_state == DONE);
   assign shifter_operand = r_shop;
   assign ok              = r_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_rot   <= '0;
         r_value <= '0;
         r_shop  <= '0;
         r_ok    <= 1'b0;
`ifdef IMM_ENCODER_MVN_EN
         r_inv   <= 1'b0;
`endif
      end else begin
         r_state <= nx_state;
         r_rot   <= nx_rot;
         r_value <= nx_value;
         r_shop  <= nx_shop;
         r_ok    <= nx_ok;
`ifdef IMM_ENCODER_MVN_EN
         r_inv   <= nx_inv;
`endif
      end
   end

   always_comb begin
      nx_state = r_state;
      nx_rot   = r_rot;
      nx_value = r_value;
      nx_shop  = r_shop;
      nx_ok    = r_ok;
`ifdef IMM_ENCODER_MVN_EN
      nx_inv   = r_inv;
`endif
      if (flush) begin
         nx_state = IDLE;
         nx_rot   = '0;
         nx_shop  = '0;
         nx_ok    = 1'b0;
`ifdef IMM_ENCODER_MVN_EN
         nx_inv   = 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  nx_state = SEARCH;
                  nx_value = value;
                  nx_rot   = '0;
                  nx_shop  = '0;
                  nx_ok    = 1'b0;
`ifdef IMM_ENCODER_MVN_EN
                  nx_inv   = 1'b0;
`endif
               end
            end
            SEARCH: begin
               if (w_hit) begin
                  nx_state = DONE;
                  nx_shop  = {r_rot, w_cand[IMM8_W-1:0]};
                  nx_ok    = 1'b1;
               end else if (r_rot == ROT_MAX) begin
`ifdef IMM_ENCODER_MVN_EN
                  nx_state = INV_SEARCH;
                  nx_rot   = '0;
`else
                  nx_state = DONE;
                  nx_shop  = '0;
                  nx_ok    = 1'b0;
`endif
               end else begin
                  nx_rot = r_rot + 4'd1;
               end
            end
`ifdef IMM_ENCODER_MVN_EN
            INV_SEARCH: begin
               if (w_hit) begin
                  nx_state = DONE;
                  nx_shop  = {r_rot, w_cand[IMM8_W-1:0]};
                  nx_ok    = 1'b1;
                  nx_inv   = 1'b1;
               end else if (r_rot == ROT_MAX) begin
                  nx_state = DONE;
                  nx_shop  = '0;
                  nx_ok    = 1'b0;
                  nx_inv   = 1'b0;
               end else begin
                  nx_rot = r_rot + 4'd1;
               end
            end
`endif
            DONE: begin
               if (out_ready) nx_state = IDLE;
            end
            default: nx_state = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed corner cases plus random values
// compared against a brute-force ROR(imm8, 2*rot) reference model.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] value = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [11:0] shifter_operand;
   logic        ok;
   logic        inv;

   int n_chk = 0;
   int n_err = 0;

`ifdef IMM_ENCODER_MVN_EN
   localparam bit MVN = 1'b1;
`else
   localparam bit MVN = 1'b0;
`endif

   imm_encoder dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .value           (value),
      .flush           (flush),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .shifter_operand (shifter_operand),
      .ok              (ok),
      .inv             (inv)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   // Brute force over every (rot, imm8) pair, smallest rot first.
   task automatic model(input logic [31:0] v, output logic [11:0] e_op, output logic e_ok,
                        output logic e_inv, output int e_lat);
      bit found;
      found = 1'b0;
      e_op = '0; e_ok = 1'b0; e_inv = 1'b0;
      e_lat = MVN ? 32 : 16;
      for (int pass = 0; pass < (MVN ? 2 : 1); pass++) begin
         logic [31:0] tgt;
         tgt = (pass == 0) ? v : ~v;
         for (int r = 0; r < 16 && !found; r++) begin
            for (int i = 0; i < 256 && !found; i++) begin
               if (ror32(i, 2 * r) == tgt) begin
                  found = 1'b1;
                  e_op  = {r[3:0], i[7:0]};
                  e_ok  = 1'b1;
                  e_inv = (pass == 1);
                  e_lat = 16 * pass + r + 1;
               end
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  in_ready, 1);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_shop"},      shifter_operand, 0);
      check({tag, "_ok"},        ok, 0);
      check({tag, "_inv"},       inv, 0);
   endtask

   task automatic accept(input logic [31:0] v);
      @(negedge clk);
      check("in_ready_before_accept", in_ready, 1);
      in_valid = 1'b1;
      value    = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      value    = $urandom;
   endtask

   task automatic run_req(input logic [31:0] v, input int hold);
      logic [11:0] e_op;
      logic        e_ok, e_inv;
      int          e_lat, cyc;
      logic [11:0] held_op;
      model(v, e_op, e_ok, e_inv, e_lat);
      accept(v);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(posedge clk);
         cyc++;
         #1;
      end
      check("latency", cyc, e_lat);
      check("shifter_operand", shifter_operand, e_op);
      check("ok", ok, e_ok);
      check("inv", inv, e_inv);
      held_op = shifter_operand;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1;
         check("hold_out_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_shop", shifter_operand, held_op);
         check("hold_ok", ok, e_ok);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("retire_out_valid", out_valid, 0);
      check("retire_in_ready", in_ready, 1);
   endtask

   initial begin
      logic [31:0] rv;
      #1;
      check_reset_outputs("reset");
      #13 rst = 1'b0;

      run_req(32'h0000_00FF, 0);
      run_req(32'hFF00_0000, 0);
      run_req(32'h0000_0104, 0);
      run_req(32'h0000_0101, 0);
      run_req(32'h0000_0000, 0);
      run_req(32'hFFFF_FF00, 0);
      run_req(32'hFFFF_FFFF, 0);
      run_req(32'h8000_0001, 5);

      // Flush in the third search cycle, with a competing in_valid on that edge.
      accept(32'h0000_0101);
      @(posedge clk);
      @(posedge clk);
      #1;
      flush    = 1'b1;
      in_valid = 1'b1;
      value    = 32'h0000_00FF;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_in_ready", in_ready, 1);
      check("flush_out_valid", out_valid, 0);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         check("flush_no_result", out_valid, 0);
      end
      run_req(32'h0003_FC00, 0);

      // Asynchronous reset pulse in the middle of a search.
      accept(32'h0000_0104);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      #12 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("post_rst_idle", out_valid, 0);
      end
      run_req(32'hFF00_0000, 0);

      for (int t = 0; t < 24; t++) begin
         case (t % 3)
            0: rv = ror32($urandom_range(0, 255), 2 * $urandom_range(0, 15));
            1: rv = ~ror32($urandom_range(0, 255), 2 * $urandom_range(0, 15));
            default: rv = $urandom;
         endcase
         run_req(rv, t % 4);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

endmodule
